mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all ports are listed below as name, direction, width, meaning.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 cpu_req  in  1  CPU access request; held high with stable cpu_addr, cpu_wen and cpu_wdata until cpu_ack.
REQ-005 cpu_addr  in  16  CPU word address.
REQ-006 cpu_wen  in  1  CPU write enable, active-low: 0 = write, 1 = read.
REQ-007 cpu_wdata  in  16  CPU write data.
REQ-008 cpu_rdata  out  16  CPU read data, valid in the cpu_ack cycle.
REQ-009 cpu_ack  out  1  one-cycle completion pulse to the CPU.
REQ-010 dma_req, dma_addr, dma_wen, dma_wdata, dma_rdata, dma_ack  SHALL mirror REQ-004..REQ-009 for the DMA/debug requester.
REQ-011 mem_cs  out  1  memory select, high for exactly one cycle per access.
REQ-012 mem_addr  out  16  registered memory address.
REQ-013 mem_wen  out  1  registered memory write enable, active-low.
REQ-014 mem_wdata  out  16  registered memory write data.
REQ-015 mem_rdata  in  16  memory read data, valid one cycle after the mem_cs cycle.

Function
REQ-016 The FSM SHALL have states IDLE, ACC_CPU, ACC_DMA, DONE_CPU and DONE_DMA.
REQ-017 In IDLE, if any request is pending, the winner SHALL be selected and its addr, wen and wdata registered onto mem_*; next state is ACC_<winner>.
REQ-018 In ACC_x, mem_cs SHALL be 1 for exactly that cycle; next state is DONE_x unconditionally.
REQ-019 In DONE_x, x_ack SHALL be 1 for one cycle, and x_rdata SHALL equal mem_rdata for a read or hold its previous value for a write.
REQ-020 Latency: request sampled in cycle N, mem_cs in N+1, ack in N+2.
REQ-021 In DONE_x, a pending request from the other requester SHALL be granted directly (next state ACC_other); the acked requester's req SHALL be ignored in that cycle; otherwise next state is IDLE.
REQ-022 Arbitration SHALL be round-robin using a last_gnt register updated at each grant; on a simultaneous request, the requester not in last_gnt wins.
REQ-023 A single requester with continuous requests SHALL be served once every 3 cycles; two contending requesters SHALL alternate with one access every 2 cycles.
REQ-024 A request deasserted before its grant SHALL be dropped with no memory access and no ack.
REQ-025 Outside the ACC and DONE states, mem_cs SHALL be 0 and both acks SHALL be 0; mem_addr, mem_wen and mem_wdata SHALL hold their last values.

Reset
REQ-026 Reset SHALL force: state IDLE, last_gnt = DMA (so the CPU wins the first tie), mem_cs 0, mem_wen 1, mem_addr 0, mem_wdata 0, cpu_ack 0, dma_ack 0, cpu_rdata 0, dma_rdata 0.
REQ-027 Reset asserted mid-access SHALL abort it: no ack is issued, and the requester re-requests after reset.

Structure
REQ-028 The package mycpu_pkg SHALL hold arb_state_t (the five states), arb_id_t (ARB_CPU, ARB_DMA), ARB_AW = 16 and ARB_DW = 16.
REQ-029 One sub-module, arb_rr_pick, SHALL be used: combinational, taking the two reqs, last_gnt and a mask, and returning the winner id and a valid flag.

Verification
REQ-030 CPU read at 0x0010 with memory returning 0xBEEF -> mem_cs in cycle 1, cpu_ack in cycle 2, cpu_rdata = 0xBEEF.
REQ-031 Simultaneous CPU write 0x1234 to 0x0002 and DMA read of 0x0003 after reset -> CPU access first, DMA mem_cs in the CPU DONE cycle, DMA ack 2 cycles after the CPU ack.
REQ-032 Both requesters held high for 8 accesses -> grants alternate C,D,C,D; 8 acks in 16 cycles.
REQ-033 DMA pulses req for 1 cycle while a CPU access is in ACC_CPU -> DMA is dropped, no dma_ack, and no extra mem_cs.
REQ-034 rst_n asserted in an ACC_DMA cycle -> mem_cs falls immediately, no dma_ack, all outputs at reset values.
REQ-035 CPU write followed by DMA read at the same address 0x00FF -> dma_rdata equals the written data 0x5A5A.

Source files
------------

// File: rtl/mycpu_pkg.sv
// Shared types for the two-requester memory arbiter: FSM states, requester ids, bus widths.
// Pure declarations; no latency or backpressure of its own.
package mycpu_pkg;

  localparam int ARB_AW = 16;
  localparam int ARB_DW = 16;

  typedef enum logic [2:0] {
    IDLE,
    ACC_CPU,
    ACC_DMA,
    DONE_CPU,
    DONE_DMA
  } arb_state_t;

  typedef enum logic {
    ARB_CPU = 1'b0,
    ARB_DMA = 1'b1
  } arb_id_t;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin pick between CPU and DMA; zero latency.
// Masked requesters are treated as idle; on a tie the one not granted last wins.
module arb_rr_pick
  import mycpu_pkg::*;
(
  input  logic       cpu_req_i,
  input  logic       dma_req_i,
  input  arb_id_t    last_gnt_i,
  input  logic [1:0] mask_i,
  output arb_id_t    win_o,
  output logic       vld_o
);

  logic cpu_ok;
  logic dma_ok;

  assign cpu_ok = cpu_req_i & ~mask_i[0];
  assign dma_ok = dma_req_i & ~mask_i[1];

  always_comb begin
    vld_o = cpu_ok | dma_ok;
    win_o = ARB_CPU;
    if (cpu_ok && dma_ok) begin
      win_o = (last_gnt_i == ARB_CPU) ? ARB_DMA : ARB_CPU;
    end else if (dma_ok) begin
      win_o = ARB_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin CPU/DMA arbiter onto a single-port memory: mem_cs one cycle after grant, ack one after that.
// Requesters hold req until ack; a request dropped before grant is silently discarded.
module mem_arbiter
  import mycpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [ARB_AW-1:0] cpu_addr,
  input  logic              cpu_wen,
  input  logic [ARB_DW-1:0] cpu_wdata,
  output logic [ARB_DW-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic [ARB_AW-1:0] dma_addr,
  input  logic              dma_wen,
  input  logic [ARB_DW-1:0] dma_wdata,
  output logic [ARB_DW-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_cs,
  output logic [ARB_AW-1:0] mem_addr,
  output logic              mem_wen,
  output logic [ARB_DW-1:0] mem_wdata,
  input  logic [ARB_DW-1:0] mem_rdata
);

  arb_state_t        state_q;
  arb_id_t           last_gnt_q;
  logic              mem_cs_q;
  logic [ARB_AW-1:0] mem_addr_q;
  logic              mem_wen_q;
  logic [ARB_DW-1:0] mem_wdata_q;
  logic              cpu_ack_q;
  logic              dma_ack_q;
  logic [ARB_DW-1:0] cpu_rdata_q;
  logic [ARB_DW-1:0] dma_rdata_q;

  logic [1:0]        pick_mask;
  arb_id_t           pick_id;
  logic              pick_vld;

  // The requester being acked this cycle must not win a back-to-back grant.
  always_comb begin
    pick_mask = 2'b00;
    if (state_q == DONE_CPU) begin
      pick_mask = 2'b01;
    end else if (state_q == DONE_DMA) begin
      pick_mask = 2'b10;
    end
  end

  arb_rr_pick u_pick (
    .cpu_req_i  (cpu_req),
    .dma_req_i  (dma_req),
    .last_gnt_i (last_gnt_q),
    .mask_i     (pick_mask),
    .win_o      (pick_id),
    .vld_o      (pick_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_gnt_q  <= ARB_DMA;
      mem_cs_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wen_q   <= 1'b1;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      mem_cs_q  <= 1'b0;
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      if (state_q == DONE_CPU && mem_wen_q) begin
        cpu_rdata_q <= mem_rdata;
      end
      if (state_q == DONE_DMA && mem_wen_q) begin
        dma_rdata_q <= mem_rdata;
      end
      case (state_q)
        ACC_CPU: begin
          cpu_ack_q <= 1'b1;
          state_q   <= DONE_CPU;
        end
        ACC_DMA: begin
          dma_ack_q <= 1'b1;
          state_q   <= DONE_DMA;
        end
        default: begin
          if (pick_vld) begin
            last_gnt_q <= pick_id;
            mem_cs_q   <= 1'b1;
            if (pick_id == ARB_CPU) begin
              mem_addr_q  <= cpu_addr;
              mem_wen_q   <= cpu_wen;
              mem_wdata_q <= cpu_wdata;
              state_q     <= ACC_CPU;
            end else begin
              mem_addr_q  <= dma_addr;
              mem_wen_q   <= dma_wen;
              mem_wdata_q <= dma_wdata;
              state_q     <= ACC_DMA;
            end
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign mem_cs    = mem_cs_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wen   = mem_wen_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;

  // Read data arrives during the DONE cycle itself, so it is passed through and captured for later.
  assign cpu_rdata = (state_q == DONE_CPU && mem_wen_q) ? mem_rdata : cpu_rdata_q;
  assign dma_rdata = (state_q == DONE_DMA && mem_wen_q) ? mem_rdata : dma_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner sequences, random traffic vs reference.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_wen, cpu_ack;
  logic        dma_req, dma_wen, dma_ack;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [15:0] dma_addr, dma_wdata, dma_rdata;
  logic        mem_cs, mem_wen;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [15:0] pre_data;
  logic [15:0] dev_mem [0:255];

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic        who;
    logic [15:0] addr;
    logic        wen;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t        vecs [10];
  logic [15:0] ref_mem [0:7];
  logic        pend [2];
  int          start [2];
  int          gap [2];
  logic [15:0] r_addr [2];
  logic        r_wen [2];
  logic [15:0] r_wdata [2];
  logic [15:0] last_rd [2];
  logic        got [2];
  int          n_cs, n_ack, lat;
  logic        cs_ok;
  logic [15:0] rd;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_wen   (cpu_wen),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .dma_req   (dma_req),
    .dma_addr  (dma_addr),
    .dma_wen   (dma_wen),
    .dma_wdata (dma_wdata),
    .dma_rdata (dma_rdata),
    .dma_ack   (dma_ack),
    .mem_cs    (mem_cs),
    .mem_addr  (mem_addr),
    .mem_wen   (mem_wen),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Memory device: write lands on the mem_cs edge, read data is valid the following cycle.
  always @(posedge clk) begin
    if (pre_we) dev_mem[pre_addr] <= pre_data;
    else if (mem_cs && !mem_wen) dev_mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_cs && mem_wen) mem_rdata <= dev_mem[mem_addr[7:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic who, input logic req, input logic [15:0] a,
                       input logic wen, input logic [15:0] wd);
    if (!who) begin
      cpu_req = req; cpu_addr = a; cpu_wen = wen; cpu_wdata = wd;
    end else begin
      dma_req = req; dma_addr = a; dma_wen = wen; dma_wdata = wd;
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cpu_req = 1'b0;
    dma_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cs"}, mem_cs, 0);
    check({tag, "_wen"}, mem_wen, 1);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_cpu_ack"}, cpu_ack, 0);
    check({tag, "_dma_ack"}, dma_ack, 0);
    check({tag, "_cpu_rdata"}, cpu_rdata, 0);
    check({tag, "_dma_rdata"}, dma_rdata, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    drive(1'b0, 1'b0, 16'h0, 1'b1, 16'h0);
    drive(1'b1, 1'b0, 16'h0, 1'b1, 16'h0);
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_cs", mem_cs, 0);

    vecs[0] = '{1'b0, 16'h0010, 1'b1, 16'h0000, 16'hBEEF};
    vecs[1] = '{1'b0, 16'h0020, 1'b0, 16'h1111, 16'hBEEF};
    vecs[2] = '{1'b1, 16'h0020, 1'b1, 16'h0000, 16'h1111};
    vecs[3] = '{1'b0, 16'h00FF, 1'b0, 16'h5A5A, 16'hBEEF};
    vecs[4] = '{1'b1, 16'h00FF, 1'b1, 16'h0000, 16'h5A5A};
    vecs[5] = '{1'b1, 16'h0030, 1'b0, 16'hC0DE, 16'h5A5A};
    vecs[6] = '{1'b0, 16'h0030, 1'b1, 16'h0000, 16'hC0DE};
    vecs[7] = '{1'b1, 16'h0010, 1'b1, 16'h0000, 16'hBEEF};
    vecs[8] = '{1'b0, 16'hFFFF, 1'b0, 16'h0001, 16'hC0DE};
    vecs[9] = '{1'b1, 16'hFFFF, 1'b1, 16'h0000, 16'h0001};

    preload(8'h10, 16'hBEEF);
    preload(8'h03, 16'h3333);

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].who, 1'b1, vecs[i].addr, vecs[i].wen, vecs[i].wdata);
      @(negedge clk);
      check($sformatf("tbl%0d_cs", i), mem_cs, 1);
      check($sformatf("tbl%0d_addr", i), mem_addr, vecs[i].addr);
      check($sformatf("tbl%0d_wen", i), mem_wen, vecs[i].wen);
      if (!vecs[i].wen) check($sformatf("tbl%0d_wdata", i), mem_wdata, vecs[i].wdata);
      @(negedge clk);
      check($sformatf("tbl%0d_ack", i), vecs[i].who ? dma_ack : cpu_ack, 1);
      check($sformatf("tbl%0d_other_ack", i), vecs[i].who ? cpu_ack : dma_ack, 0);
      check($sformatf("tbl%0d_rdata", i), vecs[i].who ? dma_rdata : cpu_rdata, vecs[i].exp_rd);
      check($sformatf("tbl%0d_done_cs", i), mem_cs, 0);
      drive(vecs[i].who, 1'b0, vecs[i].addr, vecs[i].wen, vecs[i].wdata);
      @(negedge clk);
      check($sformatf("tbl%0d_post_ack", i), cpu_ack | dma_ack, 0);
      check($sformatf("tbl%0d_post_cs", i), mem_cs, 0);
    end

    // Simultaneous requests after reset: CPU first; DMA is granted in the CPU DONE cycle.
    do_reset();
    drive(1'b0, 1'b1, 16'h0002, 1'b0, 16'h1234);
    drive(1'b1, 1'b1, 16'h0003, 1'b1, 16'h0000);
    @(negedge clk);
    check("tie_c1_cs", mem_cs, 1);
    check("tie_c1_addr", mem_addr, 16'h0002);
    check("tie_c1_wen", mem_wen, 0);
    check("tie_c1_wdata", mem_wdata, 16'h1234);
    @(negedge clk);
    check("tie_c2_cpu_ack", cpu_ack, 1);
    check("tie_c2_dma_ack", dma_ack, 0);
    drive(1'b0, 1'b0, 16'h0002, 1'b0, 16'h1234);
    @(negedge clk);
    check("tie_c3_cs", mem_cs, 1);
    check("tie_c3_addr", mem_addr, 16'h0003);
    check("tie_c3_wen", mem_wen, 1);
    check("tie_c3_acks", cpu_ack | dma_ack, 0);
    @(negedge clk);
    check("tie_c4_dma_ack", dma_ack, 1);
    check("tie_c4_dma_rdata", dma_rdata, 16'h3333);
    drive(1'b1, 1'b0, 16'h0003, 1'b1, 16'h0000);
    @(negedge clk);
    check("tie_c5_cs", mem_cs, 0);
    check("tie_c5_dma_ack", dma_ack, 0);

    n_ack = 0;
    drive(1'b0, 1'b1, 16'h0010, 1'b1, 16'h0000);
    drive(1'b1, 1'b1, 16'h0020, 1'b1, 16'h0000);
    for (int off = 1; off <= 16; off++) begin
      @(negedge clk);
      check($sformatf("alt%0d_cpu_ack", off), cpu_ack, (off % 4) == 2);
      check($sformatf("alt%0d_dma_ack", off), dma_ack, (off % 4) == 0);
      check($sformatf("alt%0d_cs", off), mem_cs, (off % 2) == 1);
      n_ack += int'(cpu_ack) + int'(dma_ack);
    end
    drive(1'b0, 1'b0, 16'h0010, 1'b1, 16'h0000);
    drive(1'b1, 1'b0, 16'h0020, 1'b1, 16'h0000);
    check("alt_ack_count", n_ack, 8);
    check("alt_cpu_rdata", cpu_rdata, 16'hBEEF);
    check("alt_dma_rdata", dma_rdata, 16'h1111);
    @(negedge clk);
    check("alt_end_cs", mem_cs, 0);

    drive(1'b0, 1'b1, 16'h0030, 1'b1, 16'h0000);
    @(negedge clk);
    check("drop_c1_cs", mem_cs, 1);
    drive(1'b1, 1'b1, 16'h0020, 1'b1, 16'h0000);
    @(negedge clk);
    check("drop_c2_cpu_ack", cpu_ack, 1);
    drive(1'b1, 1'b0, 16'h0020, 1'b1, 16'h0000);
    drive(1'b0, 1'b0, 16'h0030, 1'b1, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("drop_w%0d_cs", k), mem_cs, 0);
      check($sformatf("drop_w%0d_dma_ack", k), dma_ack, 0);
    end

    drive(1'b1, 1'b1, 16'h0020, 1'b1, 16'h0000);
    @(negedge clk);
    check("rst_acc_cs", mem_cs, 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    drive(1'b1, 1'b0, 16'h0020, 1'b1, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rst_w%0d_dma_ack", k), dma_ack, 0);
      check($sformatf("rst_w%0d_cs", k), mem_cs, 0);
    end
    drive(1'b1, 1'b1, 16'h0020, 1'b1, 16'h0000);
    @(negedge clk);
    check("rst_rereq_cs", mem_cs, 1);
    @(negedge clk);
    check("rst_rereq_ack", dma_ack, 1);
    check("rst_rereq_rdata", dma_rdata, 16'h1111);
    drive(1'b1, 1'b0, 16'h0020, 1'b1, 16'h0000);

    do_reset();
    for (int a = 0; a < 8; a++) begin
      preload(8'(a), 16'hA000 | 16'(a));
      ref_mem[a] = 16'hA000 | 16'(a);
    end
    for (int s = 0; s < 2; s++) begin
      pend[s] = 1'b0; gap[s] = 0; last_rd[s] = 16'h0;
      r_addr[s] = '0; r_wen[s] = 1'b1; r_wdata[s] = '0; start[s] = 0;
    end
    n_cs = 0;
    n_ack = 0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      @(negedge clk);
      got[0] = cpu_ack;
      got[1] = dma_ack;
      check("rnd_dual_ack", got[0] & got[1], 0);
      if (mem_cs) begin
        n_cs++;
        cs_ok = (pend[0] && mem_addr == r_addr[0] && mem_wen == r_wen[0]) ||
                (pend[1] && mem_addr == r_addr[1] && mem_wen == r_wen[1]);
        check("rnd_cs_owner", cs_ok, 1);
      end
      for (int s = 0; s < 2; s++) begin
        if (got[s]) begin
          n_ack++;
          check($sformatf("rnd_ack_pending_%0d", s), pend[s], 1);
          lat = cyc - start[s];
          check($sformatf("rnd_latency_%0d", s), (lat >= 2 && lat <= 4), 1);
          if (r_wen[s]) last_rd[s] = ref_mem[r_addr[s][2:0]];
          else ref_mem[r_addr[s][2:0]] = r_wdata[s];
          rd = (s == 1) ? dma_rdata : cpu_rdata;
          check($sformatf("rnd_rdata_%0d", s), rd, last_rd[s]);
          pend[s] = 1'b0;
          gap[s] = int'($urandom_range(0, 2));
          drive(1'(s), 1'b0, r_addr[s], r_wen[s], r_wdata[s]);
        end else if (!pend[s]) begin
          if (gap[s] > 0) begin
            gap[s]--;
          end else if (cyc < 600) begin
            pend[s] = 1'b1;
            start[s] = cyc;
            r_addr[s] = 16'($urandom_range(0, 7));
            r_wen[s] = 1'($urandom_range(0, 1));
            r_wdata[s] = 16'($urandom);
            drive(1'(s), 1'b1, r_addr[s], r_wen[s], r_wdata[s]);
          end
        end
      end
    end
    check("rnd_cs_vs_ack", n_cs, n_ack);
    check("rnd_drained", pend[0] | pend[1], 0);
    check("rnd_activity", n_ack > 100, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
